// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 8-bit ALU operation sequencer.
package alu_seq_pkg;

    // Operand width; results are twice this wide to hold a full product.
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MUL = 3'b110,
        OP_ILL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // An opcode is legal unless it is the reserved code or a multiply
    // on a build without the multiplier.
    function automatic logic op_is_legal(input opcode_e op, input logic mul_en);
        logic legal;
        case (op)
            OP_ILL:  legal = 1'b0;
            OP_MUL:  legal = mul_en;
            default: legal = 1'b1;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bus between a requester and the ALU sequencer.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            opcode;
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   result;
    logic                  carry;
    logic                  zero;
    logic                  err;
    logic                  busy;

    modport master (
        output req_valid, opcode, a, b, rsp_ready,
        input  req_ready, rsp_valid, result, carry, zero, err, busy
    );

    modport slave (
        input  req_valid, opcode, a, b, rsp_ready,
        output req_ready, rsp_valid, result, carry, zero, err, busy
    );

endinterface

// File: rtl/alu8_comb.sv
// Combinational 8-bit operation unit: ripple adder/subtractor and logic ops.
module alu8_comb
    import alu_seq_pkg::*;
(
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o,
    output logic              co_o
);

    logic [DATA_W-1:0] b_eff_s;
    logic [DATA_W-1:0] sum_s;
    logic              carry_s;

    // Ripple-carry adder; subtract inverts b and injects a carry-in of one.
    always_comb begin
        b_eff_s = (op_i == OP_SUB) ? ~b_i : b_i;
        carry_s = (op_i == OP_SUB);
        sum_s   = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            sum_s[i] = a_i[i] ^ b_eff_s[i] ^ carry_s;
            carry_s  = (a_i[i] & b_eff_s[i]) | (carry_s & (a_i[i] ^ b_eff_s[i]));
        end
    end

    // Select the operation result; only the arithmetic ops report a carry.
    always_comb begin
        y_o  = {DATA_W{1'b0}};
        co_o = 1'b0;
        case (op_i)
            OP_ADD,
            OP_SUB: begin
                y_o  = sum_s;
                co_o = carry_s;
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOT:  y_o = ~a_i;
            default: begin
                y_o  = {DATA_W{1'b0}};
                co_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer: accepts one operation, runs it through the shared 8-bit unit
// (once, or eight shift-add steps for multiply) and holds the response.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus
);

    state_e                state_q, state_d;
    opcode_e               op_q, op_d;
    logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  mul_load_q, mul_load_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;
    logic                  err_q, err_d;

    logic                  accept_s;
    opcode_e               alu_op_s;
    logic [DATA_W-1:0]     alu_a_s, alu_b_s, alu_y_s;
    logic                  alu_co_s;
    logic [2*DATA_W-1:0]   exec_res_s;

    assign accept_s = bus.req_valid && (state_q == ST_IDLE);

    alu8_comb u_alu (
        .op_i (alu_op_s),
        .a_i  (alu_a_s),
        .b_i  (alu_b_s),
        .y_o  (alu_y_s),
        .co_o (alu_co_s)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if ((opcode_e'(bus.opcode) == OP_MUL) && MUL_EN) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_MUL: begin
                if (!mul_load_q && (cnt_q == 3'd7)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand mux for the shared unit: multiply steps add a into the upper
    // accumulator byte when the current multiplier bit is set.
    always_comb begin
        if (state_q == ST_MUL) begin
            alu_op_s = OP_ADD;
            alu_a_s  = acc_q[2*DATA_W-1:DATA_W];
            alu_b_s  = acc_q[0] ? a_q : {DATA_W{1'b0}};
        end else begin
            alu_op_s = op_q;
            alu_a_s  = a_q;
            alu_b_s  = b_q;
        end
    end

    // Datapath next-state: operand capture, single-cycle execute, shift-add multiply.
    always_comb begin
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        mul_load_d = mul_load_q;
        acc_d      = acc_q;
        result_d   = result_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        err_d      = err_q;
        exec_res_s = {{DATA_W{1'b0}}, alu_y_s};
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d       = opcode_e'(bus.opcode);
                    a_d        = bus.a;
                    b_d        = bus.b;
                    cnt_d      = 3'd0;
                    mul_load_d = 1'b1;
                end else begin
                    op_d = op_q;
                end
            end
            ST_EXEC: begin
                if (op_is_legal(op_q, MUL_EN)) begin
                    result_d = exec_res_s;
                    carry_d  = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_co_s : 1'b0;
                    zero_d   = (exec_res_s == {2*DATA_W{1'b0}});
                    err_d    = 1'b0;
                end else begin
                    result_d = {2*DATA_W{1'b0}};
                    carry_d  = 1'b0;
                    zero_d   = 1'b1;
                    err_d    = 1'b1;
                end
            end
            ST_MUL: begin
                if (mul_load_q) begin
                    // First multiply cycle loads the multiplier into the low byte.
                    acc_d      = {{DATA_W{1'b0}}, b_q};
                    mul_load_d = 1'b0;
                end else begin
                    acc_d = {alu_co_s, alu_y_s, acc_q[DATA_W-1:1]};
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        result_d = acc_d;
                        carry_d  = 1'b0;
                        zero_d   = (acc_d == {2*DATA_W{1'b0}});
                        err_d    = 1'b0;
                    end else begin
                        result_d = result_q;
                    end
                end
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    // Output decode from the state and result registers.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.busy      = (state_q != ST_IDLE);
        bus.rsp_valid = (state_q == ST_DONE);
        bus.result    = result_q;
        bus.carry     = carry_q;
        bus.zero      = zero_q;
        bus.err       = err_q;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            a_q        <= {DATA_W{1'b0}};
            b_q        <= {DATA_W{1'b0}};
            cnt_q      <= 3'd0;
            mul_load_q <= 1'b0;
            acc_q      <= {2*DATA_W{1'b0}};
            result_q   <= {2*DATA_W{1'b0}};
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            mul_load_q <= mul_load_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed corner cases plus random operations, each
// compared against an arithmetic reference model of the operation rules.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if bus1 ();
    alu_op_sequencer_if bus0 ();

    alu_op_sequencer #(.MUL_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_op_sequencer #(.MUL_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    typedef struct packed {
        logic        req_ready;
        logic        rsp_valid;
        logic        busy;
        logic        carry;
        logic        zero;
        logic        err;
        logic [15:0] result;
    } obs_t;

    function automatic obs_t get_obs(input bit u0);
        obs_t o;
        if (u0) o = '{bus0.req_ready, bus0.rsp_valid, bus0.busy, bus0.carry, bus0.zero, bus0.err, bus0.result};
        else    o = '{bus1.req_ready, bus1.rsp_valid, bus1.busy, bus1.carry, bus1.zero, bus1.err, bus1.result};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit u0, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (u0) begin
            bus0.req_valid = v; bus0.opcode = op; bus0.a = a; bus0.b = b;
        end else begin
            bus1.req_valid = v; bus1.opcode = op; bus1.a = a; bus1.b = b;
        end
    endtask

    task automatic set_rdy(input bit u0, input logic r);
        if (u0) bus0.rsp_ready = r;
        else    bus1.rsp_ready = r;
    endtask

    // Reference model: expected response and latency from the operation rules.
    task automatic ref_op(input bit mul_en, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, output logic [15:0] res, output logic c,
                          output logic z, output logic e, output int lat);
        int ia, ib;
        ia = int'(a); ib = int'(b);
        c = 1'b0; e = 1'b0; lat = 1; res = 16'h0000;
        case (op)
            3'd0: begin res = 16'((ia + ib) % 256); c = ((ia + ib) > 255); end
            3'd1: begin res = 16'((ia - ib + 256) % 256); c = (ia >= ib); end
            3'd2: res = {8'h00, a & b};
            3'd3: res = {8'h00, a | b};
            3'd4: res = {8'h00, a ^ b};
            3'd5: res = {8'h00, ~a};
            3'd6: begin
                if (mul_en) begin res = 16'(ia * ib); lat = 9; end
                else        begin res = 16'h0000; e = 1'b1; end
            end
            default: begin res = 16'h0000; e = 1'b1; end
        endcase
        z = (res == 16'h0000);
    endtask

    // One full transaction: accept, wait for the response, hold, release.
    task automatic do_op(input bit u0, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int hold, input string tag);
        logic [15:0] er;
        logic        ec, ez, ee;
        int          elat, lat;
        obs_t        o, held;
        ref_op(!u0, op, a, b, er, ec, ez, ee, elat);
        o = get_obs(u0);
        check({tag, ".rdy_idle"}, 32'(o.req_ready), 32'd1);
        set_req(u0, 1'b1, op, a, b);
        tick();
        set_req(u0, 1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
        lat = 0;
        o = get_obs(u0);
        while (!o.rsp_valid && lat < 20) begin
            check({tag, ".busy"}, 32'({o.busy, o.req_ready}), 32'd2);
            tick();
            lat++;
            o = get_obs(u0);
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".resp"}, 32'({o.result, o.carry, o.zero, o.err}), 32'({er, ec, ez, ee}));
        check({tag, ".done_ctl"}, 32'({o.busy, o.req_ready}), 32'd2);
        held = o;
        for (int i = 0; i < hold; i++) begin
            tick();
            o = get_obs(u0);
            check({tag, ".hold"}, 32'(o), 32'(held));
        end
        set_rdy(u0, 1'b1);
        tick();
        set_rdy(u0, 1'b0);
        o = get_obs(u0);
        check({tag, ".release"}, 32'({o.req_ready, o.rsp_valid, o.busy}), 32'd4);
    endtask

    initial begin
        obs_t o;
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
        set_rdy(1'b0, 1'b0);
        set_rdy(1'b1, 1'b0);
        repeat (2) tick();
        o = get_obs(1'b0);
        check("reset1", 32'({o.rsp_valid, o.busy, o.carry, o.zero, o.err, o.result}), 32'd0);
        o = get_obs(1'b1);
        check("reset0", 32'({o.rsp_valid, o.busy, o.carry, o.zero, o.err, o.result}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst1", 32'(bus1.req_ready), 32'd1);
        check("rdy_after_rst0", 32'(bus0.req_ready), 32'd1);

        // Directed corner cases.
        do_op(1'b0, 3'b000, 8'hFF, 8'h01, 0, "add_ovf");
        check("add_ovf.const", 32'({bus1.result, bus1.carry, bus1.zero}), 32'({16'h0000, 1'b1, 1'b1}));
        do_op(1'b0, 3'b001, 8'h05, 8'h07, 0, "sub_borrow");
        do_op(1'b0, 3'b001, 8'h07, 8'h05, 0, "sub_noborrow");
        do_op(1'b0, 3'b110, 8'hFF, 8'hFF, 0, "mul_ff");
        check("mul_ff.const", 32'(bus1.result), 32'h0000FE01);
        do_op(1'b0, 3'b010, 8'hF0, 8'h3C, 5, "and_hold5");
        do_op(1'b0, 3'b110, 8'h0D, 8'hB3, 5, "mul_hold5");
        do_op(1'b0, 3'b101, 8'hFF, 8'h00, 0, "not_zero");
        do_op(1'b0, 3'b111, 8'h12, 8'h34, 0, "ill111");
        do_op(1'b0, 3'b110, 8'h00, 8'h9A, 0, "mul_zero");

        // Reset landing on multiply step 4 discards the operation.
        set_req(1'b0, 1'b1, 3'b110, 8'h12, 8'h34);
        tick();
        set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        o = get_obs(1'b0);
        check("mid_mul_rst", 32'({o.rsp_valid, o.busy, o.carry, o.zero, o.err, o.result}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            o = get_obs(1'b0);
            check("post_rst_idle", 32'({o.rsp_valid, o.busy, o.req_ready}), 32'd1);
        end
        do_op(1'b0, 3'b000, 8'h10, 8'h20, 0, "add_after_rst");
        check("add_after_rst.const", 32'(bus1.result), 32'h00000030);

        // Build without the multiplier: both 111 and 110 are illegal.
        do_op(1'b1, 3'b111, 8'h5A, 8'hA5, 0, "nomul_ill111");
        do_op(1'b1, 3'b110, 8'h03, 8'h04, 0, "nomul_mul");
        do_op(1'b1, 3'b000, 8'h80, 8'h80, 2, "nomul_add");

        // Random operations on both builds.
        for (int i = 0; i < 24; i++) begin
            do_op(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 3)), "rand1");
        end
        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  int'($urandom_range(0, 2)), "rand0");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: MUL_EN, default 1, 1 enables the multi-cycle multiply opcode; 0 makes it illegal.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 Port: req_valid  in  1  requester presents an operation.
REQ-005 Port: req_ready  out  1  sequencer accepts the operation this cycle.
REQ-006 Port: opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT(a), 110 MUL, 111 illegal.
REQ-007 Port: a, b  in  8 each  operands, unsigned.
REQ-008 Port: rsp_valid  out  1  result available.
REQ-009 Port: rsp_ready  in  1  consumer takes the result.
REQ-010 Port: result  out  16  operation result.
REQ-011 Port: carry, zero, err  out  1 each  carry-out / no-borrow flag, result==0 flag, illegal-opcode flag.
REQ-012 Port: busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, MUL, DONE.
REQ-014 req_ready SHALL be 1 only in IDLE; an operation is accepted when req_valid && req_ready on a rising edge, and opcode/a/b are captured into internal registers at that edge.
REQ-015 IDLE -> MUL on acceptance of MUL with MUL_EN=1; IDLE -> EXEC on any other accepted opcode.
REQ-016 EXEC SHALL last exactly one cycle, register result/flags, then go to DONE; rsp_valid SHALL rise 1 cycle after acceptance.
REQ-017 MUL SHALL perform 8 shift-add steps with a 3-bit step counter (0..7), one step per cycle, LSB-first on multiplier b, adding a into the upper accumulator byte through the 8-bit adder; after step 7 -> DONE; rsp_valid SHALL rise exactly 9 cycles after acceptance.
REQ-018 DONE holds result, carry, zero, err stable while rsp_valid=1 and rsp_ready=0; DONE -> IDLE on rsp_ready=1; no new request is accepted in that same cycle.
REQ-019 ADD: result = {8'h00, a+b}, carry = bit-8 carry-out.
REQ-020 SUB: computed as a + ~b + 1; result = {8'h00, diff}; carry = 1 when a >= b (no borrow).
REQ-021 AND/OR/XOR/NOT: result[7:0] = bitwise op, result[15:8]=0, carry=0.
REQ-022 MUL: result = full 16-bit unsigned product, carry=0.
REQ-023 Illegal opcode (111, or 110 with MUL_EN=0): takes EXEC path, result=0, carry=0, zero=1, err=1; err=0 for all legal opcodes.
REQ-024 zero SHALL equal (result==16'h0000) for every completed operation.
REQ-025 Operand or opcode changes after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-026 While rst_n=0 at a rising edge: state=IDLE, step counter=0, result=0, carry=0, zero=0, err=0, rsp_valid=0, busy=0; req_ready=1 from the first cycle after rst_n returns to 1.
REQ-027 Reset in EXEC, MUL or DONE SHALL discard the operation; no rsp_valid is produced for it.

Structure
REQ-028 Shared package alu_seq_pkg SHALL hold the width constant (8), the opcode enumeration and the FSM state enumeration.
REQ-029 One sub-module alu8_comb SHALL hold the combinational 8-bit op unit (ripple adder with conditional b inversion/carry-in, AND/OR/XOR/NOT), shared by EXEC and every MUL step; the sequencer holds all registers.

Verification
REQ-030 ADD a=0xFF, b=0x01 -> 1 cycle later rsp_valid=1, result=0x0000, carry=1, zero=1, err=0.
REQ-031 SUB a=0x05, b=0x07 -> result=0x00FE, carry=0, zero=0; SUB a=0x07, b=0x05 -> result=0x0002, carry=1.
REQ-032 MUL a=0xFF, b=0xFF -> rsp_valid exactly 9 cycles after acceptance, result=0xFE01, busy=1 throughout, req_ready=0 throughout.
REQ-033 Any op with rsp_ready held 0 for 5 cycles -> result/flags stable, req_ready=0; release -> IDLE next cycle, req_ready=1.
REQ-034 rst_n=0 on MUL step 4 -> next cycle all outputs at reset values, no rsp_valid; a new ADD 0x10+0x20 -> result=0x0030.
REQ-035 opcode=111, then MUL with MUL_EN=0 -> result=0, zero=1, err=1, 1-cycle latency each.
